// File: rtl/palette_colorizer_pkg.sv
// Shared constants and helpers for the palette colorizer: default palette
// colors (RGB444), palette geometry and the pixel-code to palette-index map.
package colorizer_pkg;

    typedef logic [11:0] rgb444_t;

    // Pixel code that lets the layer underneath show through.
    localparam int TRANSPARENT_CODE = 0;

    localparam rgb444_t RGB_BLACK   = 12'h000;
    localparam rgb444_t RGB_WHITE   = 12'hFFF;
    localparam rgb444_t RGB_BLUE    = 12'h00F;
    localparam rgb444_t RGB_MAGENTA = 12'hF0F;
    localparam rgb444_t RGB_YELLOW  = 12'hFF0;
    localparam rgb444_t RGB_RED     = 12'hF00;

    // Number of palette entries: world codes first, then one block per icon layer.
    function automatic int pal_depth(int world_w, int icon_w, int num_icons);
        return (1 << world_w) + num_icons * (1 << icon_w);
    endfunction

    // World code w sits at index w; layer k code c sits after the world block.
    function automatic int pal_index(bit is_icon, int layer, int code,
                                     int world_w, int icon_w);
        if (is_icon)
            return (1 << world_w) + layer * (1 << icon_w) + code;
        return code;
    endfunction

    // Power-up color of palette entry idx.
    function automatic rgb444_t default_rgb444(int idx, int world_w, int icon_w,
                                               int num_icons);
        int      world_n;
        int      icon_n;
        int      rel;
        rgb444_t c;
        world_n = 1 << world_w;
        icon_n  = 1 << icon_w;
        c       = RGB_BLACK;
        if (idx < world_n) begin
            case (idx)
                0:       c = RGB_WHITE;    // background
                2:       c = RGB_BLUE;     // obstruction
                3:       c = RGB_MAGENTA;  // reserved
                default: c = RGB_BLACK;    // line and anything wider
            endcase
        end else begin
            rel = idx - world_n;
            if ((rel / icon_n) < num_icons) begin
                case (rel % icon_n)
                    1:       c = RGB_YELLOW;
                    3:       c = RGB_RED;
                    default: c = RGB_BLACK;
                endcase
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/palette_colorizer_if.sv
// Palette configuration port: valid/ready request with a read-data pulse back.
interface palette_colorizer_if #(
    parameter int AW = 4,
    parameter int DW = 12
);
    logic          Cfg_valid;
    logic          Cfg_ready;
    logic          Cfg_we;
    logic [AW-1:0] Cfg_addr;
    logic [DW-1:0] Cfg_wdata;
    logic [DW-1:0] Cfg_rdata;
    logic          Cfg_rvalid;

    modport master (
        output Cfg_valid, Cfg_we, Cfg_addr, Cfg_wdata,
        input  Cfg_ready, Cfg_rdata, Cfg_rvalid
    );

    modport slave (
        input  Cfg_valid, Cfg_we, Cfg_addr, Cfg_wdata,
        output Cfg_ready, Cfg_rdata, Cfg_rvalid
    );
endinterface

// File: rtl/palette_colorizer_palette_regfile.sv
// Palette register file: reset-loaded defaults, one write port, a synchronous
// pixel lookup port and a synchronous config read port.
module palette_regfile
    import colorizer_pkg::*;
#(
    parameter int COLOR_W   = 4,
    parameter int WORLD_W   = 2,
    parameter int ICON_W    = 2,
    parameter int NUM_ICONS = 2,
    parameter int PAL_DEPTH = pal_depth(WORLD_W, ICON_W, NUM_ICONS),
    parameter int PAL_AW    = $clog2(PAL_DEPTH)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 wr_en,
    input  logic [PAL_AW-1:0]    wr_addr,
    input  logic [3*COLOR_W-1:0] wr_data,
    input  logic [PAL_AW-1:0]    lk_addr,
    output logic [3*COLOR_W-1:0] lk_data,
    input  logic                 rd_en,
    input  logic [PAL_AW-1:0]    rd_addr,
    output logic [3*COLOR_W-1:0] rd_data,
    output logic                 rd_valid
);
    localparam int DW = 3 * COLOR_W;
    localparam logic [PAL_AW:0] DEPTH_V = (PAL_AW+1)'(PAL_DEPTH);

    // Widen/narrow each RGB444 channel to COLOR_W, filling extra low bits with the channel MSB.
    function automatic logic [DW-1:0] scale_rgb(rgb444_t c);
        logic [DW-1:0] res;
        logic [3:0]    ch;
        res = '0;
        for (int n = 0; n < 3; n++) begin
            ch = c[n*4 +: 4];
            for (int b = 0; b < COLOR_W; b++) begin
                if (b >= COLOR_W - 4)
                    res[n*COLOR_W + b] = ch[b - (COLOR_W - 4)];
                else
                    res[n*COLOR_W + b] = ch[3];
            end
        end
        return res;
    endfunction

    logic [DW-1:0] mem      [PAL_DEPTH];
    logic [DW-1:0] defaults [PAL_DEPTH];
    logic          wr_in_range;
    logic          rd_in_range;

    for (genvar i = 0; i < PAL_DEPTH; i++) begin : g_dflt
        assign defaults[i] = scale_rgb(default_rgb444(i, WORLD_W, ICON_W, NUM_ICONS));
    end

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_V);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_V);

    // Palette storage: defaults on reset, in-range config writes otherwise.
    // NOTE: every entry has a reset value, so this is a flop array, not a RAM;
    // it must stay small enough for that to be acceptable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < PAL_DEPTH; i++)
                mem[i] <= defaults[i];
        end else if (wr_en && wr_in_range) begin
            // NOTE: non-blocking, so a lookup at this same edge still sees the old color.
            mem[wr_addr] <= wr_data;
        end
    end

    // Pixel lookup port, one cycle of latency.
    always_ff @(posedge Clock) begin
        if (Reset)
            lk_data <= '0;
        else
            lk_data <= mem[lk_addr];
    end

    // Config read port: data and a one-cycle valid pulse after acceptance.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_in_range ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/palette_colorizer.sv
// Pixel colorizer: picks the highest-priority visible icon layer (else the
// world code), looks it up in the programmable palette and blanks outside video.
module palette_colorizer
    import colorizer_pkg::*;
#(
    parameter int COLOR_W      = 4,
    parameter int WORLD_W      = 2,
    parameter int ICON_W       = 2,
    parameter int NUM_ICONS    = 2,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [WORLD_W-1:0]          World_px,
    input  logic [NUM_ICONS*ICON_W-1:0] Icon_px,
    input  logic                        Video_on,
    input  logic                        Frame_tick,
    input  logic [NUM_ICONS-1:0]        Blink_en,
    palette_colorizer_if.slave          cfg,
    output logic [COLOR_W-1:0]          red,
    output logic [COLOR_W-1:0]          green,
    output logic [COLOR_W-1:0]          blue
);
    localparam int PAL_DEPTH = pal_depth(WORLD_W, ICON_W, NUM_ICONS);
    localparam int PAL_AW    = $clog2(PAL_DEPTH);
    localparam int DW        = 3 * COLOR_W;
    localparam int CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // Blink phase states.
    localparam logic PHASE_VISIBLE = 1'b0;
    localparam logic PHASE_HIDDEN  = 1'b1;

    logic [CNT_W-1:0]  blink_cnt;
    logic              blink_phase;
    logic [PAL_AW-1:0] sel_idx;
    logic [ICON_W-1:0] layer_code;
    logic              video_s1;
    logic [PAL_AW-1:0] idx_s1;
    logic              video_s2;
    logic [DW-1:0]     lk_data;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              cfg_fire;

    // Frame-tick counter; toggles the blink phase every BLINK_FRAMES ticks.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            blink_cnt   <= '0;
            blink_phase <= PHASE_VISIBLE;
        end else if (Frame_tick) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Layer priority: walk from lowest priority up so layer 0 has the last word.
    // NOTE: both outputs get a default first, otherwise a latch is inferred.
    always_comb begin
        sel_idx    = PAL_AW'(pal_index(1'b0, 0, int'(World_px), WORLD_W, ICON_W));
        layer_code = '0;
        for (int k = NUM_ICONS - 1; k >= 0; k--) begin
            layer_code = Icon_px[k*ICON_W +: ICON_W];
            if (layer_code != ICON_W'(TRANSPARENT_CODE) &&
                !(Blink_en[k] && blink_phase == PHASE_HIDDEN))
                sel_idx = PAL_AW'(pal_index(1'b1, k, int'(layer_code), WORLD_W, ICON_W));
        end
    end

    // Stage 1: register the chosen palette index and the video qualifier.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            video_s1 <= 1'b0;
            idx_s1   <= '0;
        end else begin
            video_s1 <= Video_on;
            idx_s1   <= sel_idx;
        end
    end

    // Stage 2 qualifier, aligned with the palette lookup data.
    always_ff @(posedge Clock) begin
        if (Reset)
            video_s2 <= 1'b0;
        else
            video_s2 <= video_s1;
    end

    assign cfg.Cfg_ready  = ~Reset;
    assign cfg_fire       = cfg.Cfg_valid && cfg.Cfg_ready;
    assign cfg.Cfg_rdata  = rd_data;
    assign cfg.Cfg_rvalid = rd_valid;

    palette_regfile #(
        .COLOR_W   (COLOR_W),
        .WORLD_W   (WORLD_W),
        .ICON_W    (ICON_W),
        .NUM_ICONS (NUM_ICONS),
        .PAL_DEPTH (PAL_DEPTH),
        .PAL_AW    (PAL_AW)
    ) u_regfile (
        .Clock    (Clock),
        .Reset    (Reset),
        .wr_en    (cfg_fire && cfg.Cfg_we),
        .wr_addr  (cfg.Cfg_addr),
        .wr_data  (cfg.Cfg_wdata),
        .lk_addr  (idx_s1),
        .lk_data  (lk_data),
        .rd_en    (cfg_fire && !cfg.Cfg_we),
        .rd_addr  (cfg.Cfg_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    assign {red, green, blue} = video_s2 ? lk_data : '0;

endmodule

// File: tb/tb_palette_colorizer.sv
// Self-checking bench for palette_colorizer: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_palette_colorizer;

    localparam int COLOR_W      = 4;
    localparam int WORLD_W      = 2;
    localparam int ICON_W       = 2;
    localparam int NUM_ICONS    = 2;
    localparam int BLINK_FRAMES = 4;
    localparam int PAL_DEPTH    = 12;
    localparam int PAL_AW       = 4;
    localparam int DW           = 12;

    logic                        Clock = 1'b0;
    logic                        Reset;
    logic [WORLD_W-1:0]          World_px;
    logic [NUM_ICONS*ICON_W-1:0] Icon_px;
    logic                        Video_on;
    logic                        Frame_tick;
    logic [NUM_ICONS-1:0]        Blink_en;
    logic [COLOR_W-1:0]          red, green, blue;

    palette_colorizer_if #(.AW(PAL_AW), .DW(DW)) cfg_bus ();

    palette_colorizer #(
        .COLOR_W      (COLOR_W),
        .WORLD_W      (WORLD_W),
        .ICON_W       (ICON_W),
        .NUM_ICONS    (NUM_ICONS),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .World_px   (World_px),
        .Icon_px    (Icon_px),
        .Video_on   (Video_on),
        .Frame_tick (Frame_tick),
        .Blink_en   (Blink_en),
        .cfg        (cfg_bus),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    always #5 Clock = ~Clock;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state.
    logic [11:0] m_pal [PAL_DEPTH];
    int          m_ticks;
    logic        m_v1;
    int          m_idx1;
    logic [11:0] m_out;
    logic        m_rvalid;
    logic [11:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Power-up palette as listed in the block description.
    function automatic logic [11:0] default_color(int idx);
        case (idx)
            0:       return 12'hFFF;
            2:       return 12'h00F;
            3:       return 12'hF0F;
            5, 9:    return 12'hFF0;
            7, 11:   return 12'hF00;
            default: return 12'h000;
        endcase
    endfunction

    // Palette index the current inputs should select.
    function automatic int pick_index();
        bit hidden;
        int code;
        hidden = ((m_ticks / BLINK_FRAMES) % 2) == 1;
        for (int k = 0; k < NUM_ICONS; k++) begin
            code = int'(Icon_px[k*ICON_W +: ICON_W]);
            if (code != 0 && !(Blink_en[k] && hidden))
                return 4 + 4 * k + code;
        end
        return int'(World_px);
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        int a;
        if (Reset) begin
            for (int i = 0; i < PAL_DEPTH; i++) m_pal[i] = default_color(i);
            m_ticks  = 0;
            m_v1     = 1'b0;
            m_idx1   = 0;
            m_out    = 12'h000;
            m_rvalid = 1'b0;
            m_rdata  = 12'h000;
        end else begin
            m_out    = m_v1 ? m_pal[m_idx1] : 12'h000;
            m_v1     = Video_on;
            m_idx1   = pick_index();
            m_rvalid = 1'b0;
            if (cfg_bus.Cfg_valid) begin
                a = int'(cfg_bus.Cfg_addr);
                if (cfg_bus.Cfg_we) begin
                    if (a < PAL_DEPTH) m_pal[a] = cfg_bus.Cfg_wdata;
                end else begin
                    m_rvalid = 1'b1;
                    m_rdata  = (a < PAL_DEPTH) ? m_pal[a] : 12'h000;
                end
            end
            if (Frame_tick) m_ticks++;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clock);
        #1;
        check("rgb", 32'({red, green, blue}), 32'(m_out));
        check("cfg_ready", 32'(cfg_bus.Cfg_ready), 32'(!Reset));
        check("cfg_rvalid", 32'(cfg_bus.Cfg_rvalid), 32'(m_rvalid));
        if (m_rvalid) check("cfg_rdata", 32'(cfg_bus.Cfg_rdata), 32'(m_rdata));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cfg_write(input int addr, input logic [11:0] data);
        cfg_bus.Cfg_valid = 1'b1;
        cfg_bus.Cfg_we    = 1'b1;
        cfg_bus.Cfg_addr  = PAL_AW'(addr);
        cfg_bus.Cfg_wdata = data;
        step();
        cfg_bus.Cfg_valid = 1'b0;
    endtask

    task automatic cfg_read(input int addr);
        cfg_bus.Cfg_valid = 1'b1;
        cfg_bus.Cfg_we    = 1'b0;
        cfg_bus.Cfg_addr  = PAL_AW'(addr);
        step();
        cfg_bus.Cfg_valid = 1'b0;
    endtask

    function automatic logic [11:0] rgb_now();
        return {red, green, blue};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset             = 1'b1;
        World_px          = '0;
        Icon_px           = '0;
        Video_on          = 1'b1;
        Frame_tick        = 1'b0;
        Blink_en          = '0;
        cfg_bus.Cfg_valid = 1'b0;
        cfg_bus.Cfg_we    = 1'b0;
        cfg_bus.Cfg_addr  = '0;
        cfg_bus.Cfg_wdata = '0;

        // Reset state.
        step();
        check("rst_rgb", 32'(rgb_now()), 32'h000);
        check("rst_rdata", 32'(cfg_bus.Cfg_rdata), 32'h000);
        check("rst_ready", 32'(cfg_bus.Cfg_ready), 32'h0);
        Reset = 1'b0;

        // Default world colors, two-cycle latency.
        steps(2); check("dflt_w0", 32'(rgb_now()), 32'hFFF);
        World_px = 2'd2; steps(2); check("dflt_w2", 32'(rgb_now()), 32'h00F);
        World_px = 2'd3; steps(2); check("dflt_w3", 32'(rgb_now()), 32'hF0F);

        // Layer priority and video gating.
        World_px = 2'd0;
        Icon_px  = {2'd1, 2'd2}; steps(2); check("prio_l0", 32'(rgb_now()), 32'h000);
        Icon_px  = {2'd1, 2'd0}; steps(2); check("prio_l1", 32'(rgb_now()), 32'hFF0);
        Video_on = 1'b0; step();  check("video_off_lat", 32'(rgb_now()), 32'hFF0);
        step();                   check("video_off", 32'(rgb_now()), 32'h000);
        Video_on = 1'b1; step();  check("video_on_lat", 32'(rgb_now()), 32'h000);
        step();                   check("video_on", 32'(rgb_now()), 32'hFF0);

        // Palette write and readback.
        Icon_px = '0;
        cfg_write(0, 12'h0A5);
        steps(2); check("wr_idx0", 32'(rgb_now()), 32'h0A5);
        cfg_read(0);
        check("rd_idx0_valid", 32'(cfg_bus.Cfg_rvalid), 32'h1);
        check("rd_idx0_data", 32'(cfg_bus.Cfg_rdata), 32'h0A5);
        step(); check("rd_pulse_end", 32'(cfg_bus.Cfg_rvalid), 32'h0);
        cfg_read(PAL_DEPTH);
        check("rd_oor_valid", 32'(cfg_bus.Cfg_rvalid), 32'h1);
        check("rd_oor_data", 32'(cfg_bus.Cfg_rdata), 32'h000);
        cfg_write(PAL_DEPTH, 12'hFFF);
        // Back-to-back reads of every entry; the model flags any stray write.
        cfg_bus.Cfg_valid = 1'b1;
        cfg_bus.Cfg_we    = 1'b0;
        for (int i = 0; i <= PAL_DEPTH; i++) begin
            cfg_bus.Cfg_addr = PAL_AW'(i);
            step();
        end
        cfg_bus.Cfg_valid = 1'b0;
        step();

        // Write/lookup collision on idx1.
        World_px = 2'd1; steps(3);
        cfg_bus.Cfg_valid = 1'b1;
        cfg_bus.Cfg_we    = 1'b1;
        cfg_bus.Cfg_addr  = 4'd1;
        cfg_bus.Cfg_wdata = 12'h123;
        step(); check("collide_old", 32'(rgb_now()), 32'h000);
        cfg_bus.Cfg_valid = 1'b0;
        step(); check("collide_new", 32'(rgb_now()), 32'h123);

        // Blink on layer 0 over world 0, starting from defaults.
        Reset = 1'b1; step(); Reset = 1'b0;
        World_px = 2'd0;
        Icon_px  = {2'd0, 2'd1};
        Blink_en = 2'b01;
        steps(2); check("blink_start", 32'(rgb_now()), 32'hFF0);
        for (int t = 1; t <= 3 * BLINK_FRAMES; t++) begin
            Frame_tick = 1'b1; step();
            Frame_tick = 1'b0; steps(2);
            check("blink", 32'(rgb_now()),
                  ((t / BLINK_FRAMES) % 2 == 1) ? 32'hFFF : 32'hFF0);
        end
        Blink_en = 2'b00; steps(2);
        check("blink_off", 32'(rgb_now()), 32'hFF0);
        for (int t = 0; t < BLINK_FRAMES + 1; t++) begin
            Frame_tick = 1'b1; step();
            Frame_tick = 1'b0; steps(2);
            check("blink_off_steady", 32'(rgb_now()), 32'hFF0);
        end

        // Reset during active video restores the default palette.
        Icon_px = '0;
        cfg_write(0, 12'h0A5);
        steps(2); check("pre_reset", 32'(rgb_now()), 32'h0A5);
        Reset = 1'b1;
        step(); check("mid_reset_rgb", 32'(rgb_now()), 32'h000);
        check("mid_reset_ready", 32'(cfg_bus.Cfg_ready), 32'h0);
        step(); check("mid_reset_rgb2", 32'(rgb_now()), 32'h000);
        Reset = 1'b0;
        steps(2); check("post_reset", 32'(rgb_now()), 32'hFFF);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            Reset             = ($urandom_range(0, 149) == 0);
            World_px          = WORLD_W'($urandom);
            Icon_px           = (NUM_ICONS*ICON_W)'($urandom);
            Video_on          = ($urandom_range(0, 7) != 0);
            Frame_tick        = ($urandom_range(0, 2) == 0);
            Blink_en          = NUM_ICONS'($urandom);
            cfg_bus.Cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_bus.Cfg_we    = 1'($urandom);
            cfg_bus.Cfg_addr  = PAL_AW'($urandom_range(0, 15));
            cfg_bus.Cfg_wdata = DW'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/palette_colorizer.md
Name: palette_colorizer

Overview:
- Parametrised next-generation colorizer. Merges one world-map pixel code with NUM_ICONS prioritised icon-layer pixel codes into a COLOR_W-per-channel RGB pixel.
- Colors come from a run-time programmable palette register file, with per-layer blink and a 2-stage output pipeline.
- Sits between the world-map/icon pixel sources and the VGA output pins.
- Palette is written and read back through a valid/ready config port driven by the host/bot controller.

Parameters:
- COLOR_W, 4, bits per R/G/B channel.
- WORLD_W, 2, world pixel code width.
- ICON_W, 2, icon pixel code width per layer; code 0 = transparent.
- NUM_ICONS, 2, number of icon layers; layer 0 has highest priority.
- BLINK_FRAMES, 16, frame ticks per blink half-period.
- Derived constants:
  - PAL_DEPTH = 2^WORLD_W + NUM_ICONS*2^ICON_W
  - PAL_AW = clog2(PAL_DEPTH)

Ports:
- Clock  in  1  pixel clock.
- Reset  in  1  synchronous, active-high.
- World_px  in  WORLD_W  world map code.
- Icon_px  in  NUM_ICONS*ICON_W  layer k at bits [k*ICON_W +: ICON_W].
- Video_on  in  1  active display region.
- Frame_tick  in  1  one-cycle pulse per frame.
- Blink_en  in  NUM_ICONS  per-layer blink enable.
- Cfg_valid  in  1  config request.
- Cfg_ready  out  1  config port can accept.
- Cfg_we  in  1  1 = write, 0 = read.
- Cfg_addr  in  PAL_AW  palette index.
- Cfg_wdata  in  3*COLOR_W  {R,G,B}.
- Cfg_rdata  out  3*COLOR_W  read data.
- Cfg_rvalid  out  1  read data valid pulse.
- red, green, blue  out  COLOR_W each  pixel color.

Behaviour:
- **Reset values:**
  - red/green/blue = 0; Cfg_rvalid = 0; Cfg_rdata = 0; Cfg_ready = 0 during Reset and 1 otherwise.
  - Blink counter = 0, phase = visible, pipeline valid bits = 0.
  - Palette loads defaults, where F = all-ones channel and 0 = zero:
    - World entries: idx0 FFF (background), idx1 000 (line), idx2 00F (obstruction), idx3 F0F (reserved, magenta).
    - Each icon layer base: code1 FF0, code2 000, code3 F00.
    - Remaining entries 000.
- **Reset mid-frame:** outputs forced 0 next cycle; programmed palette lost and defaults restored.
- **Palette map:**
  - World code w maps to index w.
  - Layer k code c maps to index 2^WORLD_W + k*2^ICON_W + c.
  - Icon entries with c = 0 are unused storage, but writable and readable.
- **Stage 1 (cycle N+1):**
  - Register Video_on.
  - Select the lowest-numbered layer k with code != 0 that is not blanked, and form its palette index; otherwise use the world index.
  - A layer is blanked when Blink_en[k] = 1 and phase = hidden.
- **Stage 2 (cycle N+2):** output = palette[index] if registered Video_on, else 0. Fixed latency is 2 cycles; there is no hold-previous behaviour for any code.
- **Blink:**
  - Counter increments on Frame_tick.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles phase.
  - Frame_tick during Reset is ignored.
  - Blink_en deasserted means the layer is always visible; phase keeps running.
- **Config handshake:**
  - A transfer occurs when Cfg_valid && Cfg_ready.
  - Write: palette updates at the clock edge. A stage-2 lookup of the same index in the same cycle returns the old color; new color from the next cycle.
  - Read: Cfg_rdata is valid with a one-cycle Cfg_rvalid pulse on the cycle after acceptance. Back-to-back reads are allowed every cycle.
  - Out-of-range address (>= PAL_DEPTH): write ignored; read returns 0 with Cfg_rvalid still pulsed.
  - Cfg_ready only depends on Reset; it never depends on Cfg_valid.

Decomposition:
- Package colorizer_pkg holds:
  - Default palette constants as 12-bit RGB444 values; the implementation scales them to COLOR_W by replicating the channel MSB.
  - The palette index function.
  - The transparent code constant (0).
- One sub-module, palette_regfile: holds the PAL_DEPTH x 3*COLOR_W registers with reset defaults, one write port, one lookup read port and one config read port, both synchronous.
- Layer priority and blink logic stay in the top.

Test Plan:
- **Reset defaults:** Reset 1 cycle; World_px=0, Icon_px=0, Video_on=1 -> rgb=FFF at cycle N+2; World_px=2 -> 00F; World_px=3 -> F0F.
- **Priority:** Icon_px layer0=2, layer1=1 -> 000; layer0=0, layer1=1 -> FF0; Video_on=0 -> 000 regardless, with 2-cycle latency on each transition.
- **Palette write/readback:**
  - Write idx0=0A5, then World_px=0 -> 0A5.
  - Read idx0 -> Cfg_rvalid pulse next cycle with 0A5.
  - Read addr PAL_DEPTH -> rdata 000, rvalid 1.
  - Write to PAL_DEPTH leaves all entries unchanged.
- **Write/lookup collision:** write idx1=123 in the same cycle as the stage-2 lookup of idx1 -> old 000 output, then 123 on the next pixel.
- **Blink:** Blink_en[0]=1, layer0 code1 over world0, BLINK_FRAMES=4 -> FF0 for 4 ticks, FFF for 4 ticks, repeating; Blink_en=0 -> steady FF0.
- **Reset mid-operation:** program idx0=0A5, assert Reset during active video -> rgb 000 while in reset, then FFF after release; Cfg_ready low during Reset.
